// File: rtl/mc_pkg.sv
// Shared constants for the mode counter: mode/direction encodings and per-mode digit limits.
package mc_pkg;

    localparam logic MODE_HEX = 1'b0;
    localparam logic MODE_BCD = 1'b1;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam logic [3:0] DIGIT_MAX_HEX = 4'hF;
    localparam logic [3:0] DIGIT_MAX_BCD = 4'h9;

    // Highest legal digit value for the given mode.
    function automatic logic [3:0] digit_max(input logic mode);
        return (mode == MODE_BCD) ? DIGIT_MAX_BCD : DIGIT_MAX_HEX;
    endfunction

endpackage

// File: rtl/mode_counter_if.sv
// Control/data bundle between the counter and its driver (master) and the counter itself (slave).
interface mode_counter_if #(
    parameter int DIGITS = 2
);
    logic                  mc_en;
    logic                  mc_mode;
    logic                  mc_dir;
    logic                  mc_load;
    logic [4*DIGITS-1:0]   mc_load_val;
    logic [4*DIGITS-1:0]   mc_count;
    logic                  mc_wrap;
    logic                  mc_load_err;

    modport master (
        output mc_en, mc_mode, mc_dir, mc_load, mc_load_val,
        input  mc_count, mc_wrap, mc_load_err
    );

    modport slave (
        input  mc_en, mc_mode, mc_dir, mc_load, mc_load_val,
        output mc_count, mc_wrap, mc_load_err
    );
endinterface

// File: rtl/mc_digit.sv
// Single 4-bit counter digit: hex or BCD, up or down, with parallel load and clear.
module mc_digit
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       dir,
    input  logic       mode,
    input  logic       load,
    input  logic       clr,
    input  logic [3:0] load_digit,
    output logic [3:0] digit,
    output logic       term,
    output logic       ill
);

    logic [3:0] dmax;

    assign dmax = digit_max(mode);

    // Terminal means this digit will roll over on its next step, which lets the next digit move.
    assign term = (dir == DIR_UP) ? (digit == dmax) : (digit == 4'd0);

    // Out-of-range BCD digits are rejected on load so the count never holds an illegal digit.
    assign ill = load && (mode == MODE_BCD) && (load_digit > DIGIT_MAX_BCD);

    // Digit register: reset > load > clear > step.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= ill ? 4'd0 : load_digit;
        end else if (clr) begin
            digit <= 4'd0;
        end else if (step) begin
            if (term) begin
                digit <= (dir == DIR_UP) ? 4'd0 : dmax;
            end else begin
                digit <= (dir == DIR_UP) ? digit + 4'd1 : digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/mode_counter.sv
// Multi-digit hex/BCD up/down counter with prescaler, parallel load, wrap and load-error pulses.
module mode_counter
    import mc_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 1,
    parameter int PS_W     = 27
) (
    input  logic           mc_clk,
    input  logic           mc_rst,
    mode_counter_if.slave  bus
);

    logic                mode_q;
    logic [PS_W-1:0]     ps;
    logic                tick;
    logic                mode_chg;
    logic                eff_mode;
    logic                wrap_q;
    logic                err_q;
    logic [DIGITS-1:0]   step;
    logic [DIGITS-1:0]   term;
    logic [DIGITS-1:0]   ill;
    logic [4*DIGITS-1:0] count_d;

    assign tick     = bus.mc_en && (ps == PS_W'(PRESCALE - 1));
    assign mode_chg = (bus.mc_mode != mode_q);

    // A load is judged against the incoming mode; counting always uses the registered mode.
    assign eff_mode = bus.mc_load ? bus.mc_mode : mode_q;

    // Ripple the step up the digits: a digit moves only when all lower digits are terminal.
    assign step[0] = tick;
    for (genvar g = 1; g < DIGITS; g++) begin : g_carry
        assign step[g] = step[g-1] & term[g-1];
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        mc_digit u_digit (
            .clk        (mc_clk),
            .rst        (mc_rst),
            .step       (step[g]),
            .dir        (bus.mc_dir),
            .mode       (eff_mode),
            .load       (bus.mc_load),
            .clr        (mode_chg),
            .load_digit (bus.mc_load_val[4*g +: 4]),
            .digit      (count_d[4*g +: 4]),
            .term       (term[g]),
            .ill        (ill[g])
        );
    end

    // Prescaler: free-runs while enabled, restarts on tick, load or mode change.
    always_ff @(posedge mc_clk) begin
        if (mc_rst) begin
            ps <= '0;
        end else if (bus.mc_load || mode_chg) begin
            ps <= '0;
        end else if (bus.mc_en) begin
            ps <= tick ? '0 : ps + PS_W'(1);
        end
    end

    // Registered mode copy, used to detect runtime mode switches.
    always_ff @(posedge mc_clk) begin
        mode_q <= bus.mc_mode;
    end

    // One-cycle wrap and load-error pulses aligned with the count they describe.
    always_ff @(posedge mc_clk) begin
        if (mc_rst) begin
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wrap_q <= tick && (&term) && !bus.mc_load && !mode_chg;
            err_q  <= bus.mc_load && (|ill);
        end
    end

    assign bus.mc_count    = count_d;
    assign bus.mc_wrap     = wrap_q;
    assign bus.mc_load_err = err_q;

endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
- Parametrised multi-digit up/down counter. A mode input selects hex (modulo 16 per digit) or BCD (modulo 10 per digit) operation at runtime.
- Adds features the single-digit up-counter/mux pairing lacks: direction control, synchronous parallel load, a built-in clock-enable prescaler and a wrap flag.
- Sits between the board clock and the LED/seven-segment display paths. It replaces separate hex and BCD counters followed by an output mux.

Parameters:
- DIGITS, 2, number of 4-bit digits; count width is 4*DIGITS.
- PRESCALE, 1, enabled clock cycles per count step; legal range ≥1; 1 means a step on every enabled cycle.
- PS_W, 27, prescaler counter width; must satisfy 2^PS_W ≥ PRESCALE.

Ports:
- mc_clk  input  1  system clock; all state changes on its rising edge.
- mc_rst  input  1  synchronous, active-high reset.
- mc_en  input  1  count enable; gates both the prescaler and the count steps.
- mc_mode  input  1  0 = hex (digit range 0..F), 1 = BCD (digit range 0..9).
- mc_dir  input  1  0 = count up, 1 = count down.
- mc_load  input  1  synchronous parallel load strobe.
- mc_load_val  input  4*DIGITS  value to load; digit i occupies bits [4i+3:4i].
- mc_count  output  4*DIGITS  registered count value.
- mc_wrap  output  1  one-cycle pulse marking a wrap of the whole counter.
- mc_load_err  output  1  one-cycle pulse marking an illegal BCD digit in a load.

Behaviour:
- Reset: mc_rst=1 at a clock edge sets mc_count=0, mc_wrap=0, mc_load_err=0, the prescaler to 0 and mode_q (the registered copy of mc_mode) to the current mc_mode.
- Priority per edge: reset > load > mode-change clear > count step.
- Prescaler: while mc_en=1, the prescaler increments each cycle. tick = mc_en and (prescaler == PRESCALE-1). On tick, the prescaler returns to 0. With mc_en=0, the prescaler holds its value.
- Count step:
  - On tick, the counter steps by one in the direction given by mc_dir, using the modulus given by mode_q.
  - Digit 0 always steps. Digit i steps only when every lower digit is at its terminal value: 9 or F when counting up, 0 when counting down.
  - Counting up, a digit at terminal value goes to 0. Counting down, a digit at 0 goes to 9 (BCD) or F (hex).
  - The new count is visible on mc_count the cycle after the tick edge (1-cycle latency).
- Wrap:
  - Counting up, a full wrap is all digits at max going to all zeros.
  - Counting down, a full wrap is all zeros going to all digits at max.
  - mc_wrap=1 for exactly the one cycle in which the wrapped value is first presented. Otherwise mc_wrap=0.
- Load:
  - mc_load=1 writes mc_load_val to mc_count and clears the prescaler. Load takes precedence over a coincident tick. mc_wrap=0 on that cycle.
  - In BCD mode, each loaded digit greater than 9 is written as 0 and mc_load_err pulses for one cycle. Legal digits are written unchanged.
  - In hex mode, mc_load_err is never asserted.
- Mode change:
  - mode_q registers mc_mode every cycle.
  - If mc_mode differs from mode_q and mc_load=0, mc_count clears to 0 and the prescaler clears, with no wrap pulse. This guarantees that no illegal BCD digit can exist.
  - If a load coincides with a mode change, the load is applied and checked against the new mc_mode.
- Direction change takes effect on the next tick, with no extra latency.
- Reset asserted mid-count or mid-prescale overrides everything in the same edge.
- mc_en=0 holds mc_count. Load, reset and mode-change clear still act while mc_en=0.

Decomposition:
- Shared package mc_pkg holds:
  - MODE_HEX=1'b0 and MODE_BCD=1'b1;
  - DIR_UP=1'b0 and DIR_DN=1'b1;
  - DIGIT_MAX_HEX=4'hF and DIGIT_MAX_BCD=4'h9.
- One sub-module, mc_digit, is a single 4-bit digit cell.
  - Inputs: step, dir, mode, load, load digit.
  - Outputs: digit value, terminal flag, illegal-load flag.
- The top module instantiates DIGITS copies of mc_digit in a generate loop, chains the terminal flags, and owns the prescaler, mode_q and the wrap/error pulses.

Test Plan:
- Hex up wrap (DIGITS=2, PRESCALE=1, mode=0, dir=0, en=1): load 8'hFE, then count → 8'hFF then 8'h00. mc_wrap=1 only on the 8'h00 cycle.
- BCD up carry (mode=1, dir=0): load 8'h19, one tick → 8'h20. Load 8'h99, one tick → 8'h00 with mc_wrap=1.
- BCD down borrow (mode=1, dir=1): load 8'h10, tick → 8'h09. From 8'h00, tick → 8'h99 with mc_wrap=1.
- Prescaler (PRESCALE=4, en=1, mode=0, up, starting from reset): the count reads 1 after 4 enabled cycles and 2 after 8. Dropping en for 3 cycles in between delays each step by exactly 3 cycles.
- Illegal BCD load (mode=1): load 8'hA7 → mc_count=8'h07 and mc_load_err pulses for 1 cycle. The same load in hex mode gives 8'hA7 with no error.
- Priority: at count 8'h35, toggle mc_mode → count=0 next cycle. Assert mc_rst together with mc_load=1 → count=0 and no mc_load_err. Assert mc_load coincident with a tick → the loaded value wins.
